// File: rtl/debouncer_pkg.sv
// debouncer_pkg: shared channel FSM state type and mask-length helper for the debouncer family
package debouncer_pkg;
  typedef enum logic [1:0] {IDLE, DEB_ON, HOLD, DEB_OFF} deb_state_t;
  function automatic int cycles(input int freq_khz, input int ms);
    return freq_khz * ms;
  endfunction
endpackage

// File: rtl/debouncer_chan.sv
// debouncer_chan: one debounced channel (synchronizer, mask FSM, strobes, optional long-press)
// Ports: clk, rst (async, active-high), x raw input, x_deb normalised level,
// press/rel one-cycle strobes (rel = release, a reserved word), long_press one-cycle strobe.
// Long-press counter exists only when DEBOUNCER_LONGPRESS_EN is defined.
module debouncer_chan import debouncer_pkg::*; #(
  parameter int   CYCLES      = 10,
  parameter int   LONG        = 50,
  parameter logic XPOL        = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic x_deb,
  output logic press,
  output logic rel,
  output logic long_press
);
  localparam int CW = $clog2(CYCLES);
  if (LONG < 1) $error("long-press threshold must be at least one cycle");
  logic [SYNC_STAGES-1:0] sync;
  logic a, done, act_n, press_n, rel_n;
  logic [CW-1:0] cnt, cnt_n;
  deb_state_t state, state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= {SYNC_STAGES{XPOL}};
    else sync <= {sync[SYNC_STAGES-2:0], x};
  assign a = sync[SYNC_STAGES-1] != XPOL;
  assign done = cnt == '0;
  // A mask period ending with the input already at the opposite level chains
  // straight into the next mask period, so no edge is lost or doubled.
  always_comb begin
    state_n = state;
    cnt_n = done ? cnt : cnt - 1'b1;
    case (state)
      IDLE:    if (a) state_n = DEB_ON;
      DEB_ON:  if (done) state_n = a ? HOLD : DEB_OFF;
      HOLD:    if (!a) state_n = DEB_OFF;
      DEB_OFF: if (done) state_n = a ? DEB_ON : IDLE;
    endcase
    if (state_n != state && state_n inside {DEB_ON, DEB_OFF}) cnt_n = CW'(CYCLES - 1);
  end
  assign act_n = state_n inside {DEB_ON, HOLD};
  assign press_n = state_n == DEB_ON && state != DEB_ON;
  assign rel_n = state_n == DEB_OFF && state != DEB_OFF;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      x_deb <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      x_deb <= act_n;
      press <= press_n;
      rel <= rel_n;
    end
`ifdef DEBOUNCER_LONGPRESS_EN
  localparam int HW = $clog2(LONG + 1);
  logic [HW-1:0] hcnt;
  // hcnt counts cycles since press and saturates at LONG, so the strobe fires once.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hcnt <= '0;
      long_press <= 1'b0;
    end else begin
      hcnt <= press_n ? '0 : (act_n && hcnt != HW'(LONG)) ? hcnt + 1'b1 : hcnt;
      long_press <= act_n && !press_n && hcnt == HW'(LONG - 1);
    end
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: rtl/debouncer_multi.sv
// debouncer_multi: N_CH independent debouncers with per-channel idle polarity
// Ports: clk, rst (async, active-high), x[N_CH] raw inputs, x_deb[N_CH] active-high levels,
// press/rel[N_CH] one-cycle strobes (rel = release), long_press[N_CH] one-cycle strobes.
// Optional long-press detection: define DEBOUNCER_LONGPRESS_EN.
module debouncer_multi import debouncer_pkg::*; #(
  parameter int              N_CH        = 4,
  parameter int              FREQ_KHZ    = 50000,
  parameter int              BOUNCE_MS   = 20,
  parameter logic [N_CH-1:0] XPOL        = {N_CH{1'b1}},
  parameter int              SYNC_STAGES = 2,
  parameter int              LONG_MS     = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] x,
  output logic [N_CH-1:0] x_deb,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] long_press
);
  localparam int CYCLES = cycles(FREQ_KHZ, BOUNCE_MS);
  if (CYCLES < 2) $error("bounce mask must be at least 2 cycles");
  if (SYNC_STAGES < 2) $error("synchronizer needs at least 2 stages");
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debouncer_chan #(
      .CYCLES(CYCLES),
      .LONG(cycles(FREQ_KHZ, LONG_MS)),
      .XPOL(XPOL[i]),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .x(x[i]),
      .x_deb(x_deb[i]),
      .press(press[i]),
      .rel(rel[i]),
      .long_press(long_press[i])
    );
  end
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: randomized and directed checks of debouncer_multi against a timestamp model
module tb_debouncer_multi;
  localparam int N = 4;
  localparam int SYNC = 2;
  localparam int CYC = 10;
  localparam int THR = 50;
  localparam logic [N-1:0] XPOL = 4'b0101;
`ifdef DEBOUNCER_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] x = XPOL;
  logic [N-1:0] act = '0;
  logic [N-1:0] x_deb, press, rel, long_press;
  logic [4*N-1:0] obs, exp_v;
  int chk = 0;
  int err = 0;
  debouncer_multi #(
    .N_CH(N), .FREQ_KHZ(10), .BOUNCE_MS(1), .XPOL(XPOL), .SYNC_STAGES(SYNC), .LONG_MS(5)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .x_deb(x_deb), .press(press), .rel(rel), .long_press(long_press)
  );
  always #5 clk = ~clk;
  // Model: a channel may flip its level only once CYC cycles have passed since its
  // last flip; the input it sees is x delayed through SYNC samples.
  logic [SYNC-1:0][N-1:0] hist;
  logic [N-1:0] m_deb, m_pr, m_rl, m_lp;
  int lock_end[N];
  int press_t[N];
  int ecount;
  always @(posedge clk or posedge rst) begin : model
    logic [N-1:0] d, p, r, l;
    int le[N];
    int pt[N];
    int e;
    if (rst) begin
      hist <= {SYNC{XPOL}};
      m_deb <= '0;
      m_pr <= '0;
      m_rl <= '0;
      m_lp <= '0;
      ecount <= 0;
      lock_end <= '{default: 0};
      press_t <= '{default: -100000};
    end else begin
      e = ecount + 1;
      d = m_deb;
      p = '0;
      r = '0;
      l = '0;
      le = lock_end;
      pt = press_t;
      for (int i = 0; i < N; i++) begin
        if (e >= le[i] && ((hist[SYNC-1][i] != XPOL[i]) != d[i])) begin
          d[i] = !d[i];
          le[i] = e + CYC;
          if (d[i]) begin
            p[i] = 1'b1;
            pt[i] = e;
          end else r[i] = 1'b1;
        end
        l[i] = LP && d[i] && e == pt[i] + THR;
      end
      ecount <= e;
      m_deb <= d;
      m_pr <= p;
      m_rl <= r;
      m_lp <= l;
      lock_end <= le;
      press_t <= pt;
      hist <= {hist[SYNC-2:0], x};
    end
  end
  assign obs = {x_deb, press, rel, long_press};
  assign exp_v = {m_deb, m_pr, m_rl, m_lp};

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== '0) begin err++; $display("FAIL reset_hold k=%0d got %h want 0", k, obs); end
      x = N'($urandom);
    end
    x = XPOL;
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== '0 || exp_v !== '0) begin err++; $display("FAIL reset_idle k=%0d got %h model %h want 0", k, obs, exp_v); end
    end
  endtask

  task automatic test_clean_press;
    int pi = -1, ri = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== exp_v) begin err++; $display("FAIL clean_model k=%0d got %h want %h", k, obs, exp_v); end
      if (press[1] && pi < 0) pi = k;
      if (rel[1] && ri < 0) ri = k;
      act[1] = k < 30;
      x = XPOL ^ act;
    end
    chk++;
    if (pi !== 3) begin err++; $display("FAIL clean_press_lat got %0d want 3", pi); end
    chk++;
    if (ri !== 33) begin err++; $display("FAIL clean_release_lat got %0d want 33", ri); end
  endtask

  task automatic test_bounce;
    int np = 0, nr = 0;
    logic last = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== exp_v) begin err++; $display("FAIL bounce_model k=%0d got %h want %h", k, obs, exp_v); end
      np += int'(press[0]);
      nr += int'(rel[0]);
      last = x_deb[0];
      act[0] = k >= 8 || (k / 2) % 2 == 0;
      x = XPOL ^ act;
    end
    chk++;
    if (np !== 1 || nr !== 0) begin err++; $display("FAIL bounce_strobes got press=%0d release=%0d want 1 0", np, nr); end
    chk++;
    if (last !== 1'b1) begin err++; $display("FAIL bounce_level got %b want 1", last); end
    act = '0;
    x = XPOL;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== exp_v) begin err++; $display("FAIL bounce_clear k=%0d got %h want %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_short_tap;
    int nd = 0, ri = -1, pi = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== exp_v) begin err++; $display("FAIL tap_model k=%0d got %h want %h", k, obs, exp_v); end
      nd += int'(x_deb[2]);
      if (press[2] && pi < 0) pi = k;
      if (rel[2] && ri < 0) ri = k;
      act[2] = k < 3;
      x = XPOL ^ act;
    end
    chk++;
    if (pi !== 3 || nd !== 10) begin err++; $display("FAIL tap_width got press@%0d width=%0d want 3 10", pi, nd); end
    chk++;
    if (ri !== 13) begin err++; $display("FAIL tap_release got %0d want 13", ri); end
  endtask

  task automatic test_independence;
    int ri3 = -1, nro = 0;
    logic [3:0] p3 = '0;
    logic [2:0] held = '0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== exp_v) begin err++; $display("FAIL indep_model k=%0d got %h want %h", k, obs, exp_v); end
      if (k == 3) p3 = press;
      if (k == 39) held = x_deb[2:0];
      if (rel[3] && ri3 < 0) ri3 = k;
      if (k < 40) nro += $countones(rel[2:0]);
      act = k >= 40 ? 4'h0 : k >= 5 ? 4'h7 : 4'hf;
      x = XPOL ^ act;
    end
    chk++;
    if (p3 !== 4'hf) begin err++; $display("FAIL indep_press got %b want 1111", p3); end
    chk++;
    if (ri3 !== 13) begin err++; $display("FAIL indep_release3 got %0d want 13", ri3); end
    chk++;
    if (nro !== 0 || held !== 3'b111) begin err++; $display("FAIL indep_others got releases=%0d level=%b want 0 111", nro, held); end
  endtask

  task automatic test_long_press;
    int nlp = 0, li = -1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== exp_v) begin err++; $display("FAIL long_model k=%0d got %h want %h", k, obs, exp_v); end
      nlp += $countones(long_press);
      if (long_press[1] && li < 0) li = k;
      act[1] = k < 60;
      x = XPOL ^ act;
    end
    chk++;
    if (nlp !== (LP ? 1 : 0) || li !== (LP ? 53 : -1)) begin
      err++; $display("FAIL long_pulse got count=%0d at %0d want %0d at %0d", nlp, li, LP ? 1 : 0, LP ? 53 : -1);
    end
    nlp = 0;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== exp_v) begin err++; $display("FAIL long_rst_model k=%0d got %h want %h", k, obs, exp_v); end
      nlp += $countones(long_press);
      rst = k == 30 || k == 31;
      act[1] = k < 40;
      x = XPOL ^ act;
    end
    rst = 1'b0;
    chk++;
    if (nlp !== 0) begin err++; $display("FAIL long_rst got count=%0d want 0", nlp); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      chk++;
      if (obs !== exp_v) begin err++; $display("FAIL random_model k=%0d got %h want %h", k, obs, exp_v); end
      if (press & rel) begin err++; $display("FAIL random_excl k=%0d got press=%b release=%b want disjoint", k, press, rel); end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, k % 400 < 200 ? 3 : 40) == 0) act[i] = !act[i];
      x = XPOL ^ act;
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_short_tap;
    test_independence;
    test_long_press;
    test_random;
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
